// File: rtl/peak_rv32im_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peak_rv32im_pkg
// Description : Shared widths, types and write-snoop match helper for the
//               RV32IM operand-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package peak_rv32im_pkg;

    localparam int TASK_W = 2;
    localparam int REG_W  = 5;
    localparam int XLEN   = 32;

    typedef logic [TASK_W-1:0] task_t;
    typedef logic [REG_W-1:0]  reg_addr_t;
    typedef logic [XLEN-1:0]   xword_t;

    // x0 is hard-wired to zero, so it never matches a write.
    function automatic logic wb_hits(input logic      we,
                                     input task_t     wb_task,
                                     input reg_addr_t wb_addr,
                                     input task_t     tag,
                                     input reg_addr_t addr);
        return we && (wb_task == tag) && (wb_addr == addr) && (addr != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/peak_rv32im_opbypass.sv
`default_nettype none
// ============================================================================
// Module      : peak_rv32im_opbypass
// Description : One source operand: same-cycle write bypass at issue, then a
//               hold register refreshed by matching writes while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module peak_rv32im_opbypass
    import peak_rv32im_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_capture,
    input  task_t     i_id_tasknum,
    input  reg_addr_t i_id_addr,
    input  logic      i_valid,
    input  logic      i_first,
    input  task_t     i_held_tasknum,
    input  reg_addr_t i_held_addr,
    input  logic      i_wb_we,
    input  task_t     i_wb_tasknum,
    input  reg_addr_t i_wb_waddr,
    input  xword_t    i_wb_wdata,
    input  xword_t    i_rf_data,
    output xword_t    o_operand
);

    logic   r_byp_hit;
    xword_t r_byp_data;
    xword_t r_hold;

    logic   w_id_hit;
    logic   w_held_hit;
    xword_t w_first_val;

    assign w_id_hit    = wb_hits(i_wb_we, i_wb_tasknum, i_wb_waddr, i_id_tasknum, i_id_addr);
    assign w_held_hit  = i_valid && wb_hits(i_wb_we, i_wb_tasknum, i_wb_waddr,
                                            i_held_tasknum, i_held_addr);
    // The register file returns pre-write data, so a write landing on the
    // issue edge must come from the captured snoop value instead.
    assign w_first_val = r_byp_hit ? r_byp_data : i_rf_data;
    assign o_operand   = i_first ? w_first_val : r_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
            r_hold     <= '0;
        end else begin
            if (i_capture) begin
                r_byp_hit  <= w_id_hit;
                r_byp_data <= i_wb_wdata;
            end
            if (w_held_hit) begin
                r_hold <= i_wb_wdata;
            end else if (i_first) begin
                r_hold <= w_first_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/peak_rv32im_opfetch.sv
`default_nettype none
// ============================================================================
// Module      : peak_rv32im_opfetch
// Description : Single-entry operand-fetch stage between decode and execute,
//               with write-back bypass and stall-time operand refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module peak_rv32im_opfetch
    import peak_rv32im_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      ID_VALID,
    output logic      ID_READY,
    input  task_t     ID_TASKNUM,
    input  reg_addr_t ID_RS1ADDR,
    input  reg_addr_t ID_RS2ADDR,
    input  xword_t    ID_PC,
    input  xword_t    ID_INST,
    output task_t     RF_TASKNUM,
    output reg_addr_t RF_RS1ADDR,
    output reg_addr_t RF_RS2ADDR,
    input  xword_t    RF_RS1,
    input  xword_t    RF_RS2,
    input  logic      WB_WE,
    input  task_t     WB_TASKNUM,
    input  reg_addr_t WB_WADDR,
    input  xword_t    WB_WDATA,
    input  logic      DBG_BUSY,
    output logic      EX_VALID,
    input  logic      EX_READY,
    output task_t     EX_TASKNUM,
    output xword_t    EX_PC,
    output xword_t    EX_INST,
    output xword_t    EX_RS1,
    output xword_t    EX_RS2
);

    logic      r_ex_valid;
    logic      r_first;
    task_t     r_tasknum;
    xword_t    r_pc;
    xword_t    r_inst;
    reg_addr_t r_rs_addr [2];

    logic      w_id_ready;
    logic      w_id_xfer;
    logic      w_ex_xfer;
    reg_addr_t w_id_addr  [2];
    xword_t    w_rf_data  [2];
    xword_t    w_operand  [2];

    assign w_id_ready = !RST && !DBG_BUSY && (!r_ex_valid || EX_READY);
    assign w_id_xfer  = ID_VALID && w_id_ready;
    assign w_ex_xfer  = r_ex_valid && EX_READY;

    assign RF_TASKNUM = ID_TASKNUM;
    assign RF_RS1ADDR = ID_RS1ADDR;
    assign RF_RS2ADDR = ID_RS2ADDR;

    assign w_id_addr[0] = ID_RS1ADDR;
    assign w_id_addr[1] = ID_RS2ADDR;
    assign w_rf_data[0] = RF_RS1;
    assign w_rf_data[1] = RF_RS2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ex_valid   <= 1'b0;
            r_first      <= 1'b0;
            r_tasknum    <= '0;
            r_pc         <= '0;
            r_inst       <= '0;
            r_rs_addr[0] <= '0;
            r_rs_addr[1] <= '0;
        end else if (w_id_xfer) begin
            r_ex_valid   <= 1'b1;
            r_first      <= 1'b1;
            r_tasknum    <= ID_TASKNUM;
            r_pc         <= ID_PC;
            r_inst       <= ID_INST;
            r_rs_addr[0] <= ID_RS1ADDR;
            r_rs_addr[1] <= ID_RS2ADDR;
        end else begin
            r_first <= 1'b0;
            if (w_ex_xfer) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_operand
        peak_rv32im_opbypass u_opbypass (
            .clk            (CLK),
            .rst            (RST),
            .i_capture      (w_id_xfer),
            .i_id_tasknum   (ID_TASKNUM),
            .i_id_addr      (w_id_addr[n]),
            .i_valid        (r_ex_valid),
            .i_first        (r_first),
            .i_held_tasknum (r_tasknum),
            .i_held_addr    (r_rs_addr[n]),
            .i_wb_we        (WB_WE),
            .i_wb_tasknum   (WB_TASKNUM),
            .i_wb_waddr     (WB_WADDR),
            .i_wb_wdata     (WB_WDATA),
            .i_rf_data      (w_rf_data[n]),
            .o_operand      (w_operand[n])
        );
    end

    assign ID_READY   = w_id_ready;
    assign EX_VALID   = r_ex_valid;
    assign EX_TASKNUM = r_tasknum;
    assign EX_PC      = r_pc;
    assign EX_INST    = r_inst;
    assign EX_RS1     = w_operand[0];
    assign EX_RS2     = w_operand[1];

endmodule
`default_nettype wire

// File: tb/tb_peak_rv32im_opfetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_peak_rv32im_opfetch
// Description : Directed vectors, corner sequences and a randomized run
//               checked against an architectural register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peak_rv32im_opfetch;
    import peak_rv32im_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ID_VALID;
    logic        ID_READY;
    logic [1:0]  ID_TASKNUM;
    logic [4:0]  ID_RS1ADDR, ID_RS2ADDR;
    logic [31:0] ID_PC, ID_INST;
    logic [1:0]  RF_TASKNUM;
    logic [4:0]  RF_RS1ADDR, RF_RS2ADDR;
    logic [31:0] RF_RS1, RF_RS2;
    logic        WB_WE;
    logic [1:0]  WB_TASKNUM;
    logic [4:0]  WB_WADDR;
    logic [31:0] WB_WDATA;
    logic        DBG_BUSY;
    logic        EX_VALID, EX_READY;
    logic [1:0]  EX_TASKNUM;
    logic [31:0] EX_PC, EX_INST, EX_RS1, EX_RS2;

    always #5 CLK = ~CLK;

    peak_rv32im_opfetch dut (
        .CLK(CLK), .RST(RST),
        .ID_VALID(ID_VALID), .ID_READY(ID_READY),
        .ID_TASKNUM(ID_TASKNUM), .ID_RS1ADDR(ID_RS1ADDR), .ID_RS2ADDR(ID_RS2ADDR),
        .ID_PC(ID_PC), .ID_INST(ID_INST),
        .RF_TASKNUM(RF_TASKNUM), .RF_RS1ADDR(RF_RS1ADDR), .RF_RS2ADDR(RF_RS2ADDR),
        .RF_RS1(RF_RS1), .RF_RS2(RF_RS2),
        .WB_WE(WB_WE), .WB_TASKNUM(WB_TASKNUM), .WB_WADDR(WB_WADDR), .WB_WDATA(WB_WDATA),
        .DBG_BUSY(DBG_BUSY),
        .EX_VALID(EX_VALID), .EX_READY(EX_READY),
        .EX_TASKNUM(EX_TASKNUM), .EX_PC(EX_PC), .EX_INST(EX_INST),
        .EX_RS1(EX_RS1), .EX_RS2(EX_RS2)
    );

    function automatic logic [31:0] init_val(input int t, input int r);
        if (r == 0) return 32'h0;
        return 32'hA000_0000 | 32'(t << 16) | 32'(r);
    endfunction

    // Register file: one-cycle read latency, read-old-data, x0 reads 0.
    logic        rf_load;
    logic [31:0] rf [4][32];
    always @(posedge CLK) begin
        if (rf_load) begin
            for (int t = 0; t < 4; t++)
                for (int r = 0; r < 32; r++)
                    rf[t][r] <= init_val(t, r);
        end else if (WB_WE && WB_WADDR != 5'd0) begin
            rf[WB_TASKNUM][WB_WADDR] <= WB_WDATA;
        end
        RF_RS1 <= rf[RF_TASKNUM][RF_RS1ADDR];
        RF_RS2 <= rf[RF_TASKNUM][RF_RS2ADDR];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        id_valid;
        logic [1:0]  tag;
        logic [4:0]  a1, a2;
        logic        wb_we;
        logic [1:0]  wb_tag;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        exp_valid;
        logic [31:0] exp_rs1, exp_rs2;
    } vec_t;

    function automatic vec_t mkv(input logic iv, input int tag, input int a1, input int a2,
                                 input logic we, input int wt, input int wa,
                                 input logic [31:0] wd, input logic ev,
                                 input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.id_valid = iv; v.tag = 2'(tag); v.a1 = 5'(a1); v.a2 = 5'(a2);
        v.wb_we = we; v.wb_tag = 2'(wt); v.wb_addr = 5'(wa); v.wb_data = wd;
        v.exp_valid = ev; v.exp_rs1 = e1; v.exp_rs2 = e2;
        return v;
    endfunction

    vec_t vt [7];

    // Architectural model: while an instruction is held, each operand must
    // equal the current register-file value of its (task, address).
    logic        m_valid, m_zero, exp_ready, id_x, ex_x;
    logic [1:0]  m_tag;
    logic [4:0]  m_a1, m_a2;
    logic [31:0] m_pc, m_inst;

    initial begin
        vt[0] = mkv(1, 1, 5, 6, 0, 0, 0, 32'h0,        1, init_val(1, 5), init_val(1, 6));
        vt[1] = mkv(1, 1, 6, 5, 0, 0, 0, 32'h0,        1, init_val(1, 6), init_val(1, 5));
        vt[2] = mkv(1, 2, 7, 3, 1, 3, 7, 32'hDEADBEEF, 1, init_val(2, 7), init_val(2, 3));
        vt[3] = mkv(1, 2, 7, 3, 1, 2, 7, 32'hDEADBEEF, 1, 32'hDEADBEEF,   init_val(2, 3));
        vt[4] = mkv(1, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 1, 32'h0,          32'h0);
        vt[5] = mkv(1, 2, 7, 7, 0, 0, 0, 32'h0,        1, 32'hDEADBEEF,   32'hDEADBEEF);
        vt[6] = mkv(0, 1, 1, 1, 0, 0, 0, 32'h0,        0, 32'h0,          32'h0);

        RST = 1'b1; rf_load = 1'b1; ID_VALID = 1'b1; ID_TASKNUM = 2'd1;
        ID_RS1ADDR = 5'd1; ID_RS2ADDR = 5'd2; ID_PC = 32'h40; ID_INST = 32'h13;
        WB_WE = 1'b0; WB_TASKNUM = 2'd0; WB_WADDR = 5'd0; WB_WDATA = 32'h0;
        DBG_BUSY = 1'b0; EX_READY = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ex_valid", 32'(EX_VALID), 32'h0);
        chk("rst_id_ready", 32'(ID_READY), 32'h0);
        chk("rst_ex_pc", EX_PC, 32'h0);
        chk("rst_ex_rs1", EX_RS1, 32'h0);
        chk("rst_ex_rs2", EX_RS2, 32'h0);
        RST = 1'b0; rf_load = 1'b0;

        for (int i = 0; i < 7; i++) begin
            ID_VALID = vt[i].id_valid; ID_TASKNUM = vt[i].tag;
            ID_RS1ADDR = vt[i].a1; ID_RS2ADDR = vt[i].a2;
            ID_PC = 32'h1000 + 32'(i) * 32'd4; ID_INST = 32'h0000_0033 + 32'(i);
            WB_WE = vt[i].wb_we; WB_TASKNUM = vt[i].wb_tag;
            WB_WADDR = vt[i].wb_addr; WB_WDATA = vt[i].wb_data;
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("vec%0d_ex_valid", i), 32'(EX_VALID), 32'(vt[i].exp_valid));
            if (vt[i].exp_valid) begin
                chk($sformatf("vec%0d_ex_pc", i), EX_PC, 32'h1000 + 32'(i) * 32'd4);
                chk($sformatf("vec%0d_ex_rs1", i), EX_RS1, vt[i].exp_rs1);
                chk($sformatf("vec%0d_ex_rs2", i), EX_RS2, vt[i].exp_rs2);
            end
        end
        WB_WE = 1'b0;

        // Stall with refresh of held rs2 x9.
        ID_VALID = 1'b1; ID_TASKNUM = 2'd1; ID_RS1ADDR = 5'd8; ID_RS2ADDR = 5'd9;
        ID_PC = 32'h200; ID_INST = 32'h0094_0433; EX_READY = 1'b0;
        @(posedge CLK); @(negedge CLK);
        ID_PC = 32'h204; ID_INST = 32'h0000_0013;
        #1;
        chk("stall_id_ready", 32'(ID_READY), 32'h0);
        chk("stall_rs1_first", EX_RS1, init_val(1, 8));
        chk("stall_rs2_first", EX_RS2, init_val(1, 9));
        @(posedge CLK); @(negedge CLK);
        WB_WE = 1'b1; WB_TASKNUM = 2'd1; WB_WADDR = 5'd9; WB_WDATA = 32'h12345678;
        @(posedge CLK); @(negedge CLK);
        WB_WE = 1'b0;
        chk("stall_valid", 32'(EX_VALID), 32'h1);
        chk("stall_rs2_refresh", EX_RS2, 32'h12345678);
        chk("stall_rs1_kept", EX_RS1, init_val(1, 8));
        chk("stall_pc_kept", EX_PC, 32'h200);
        chk("stall_inst_kept", EX_INST, 32'h0094_0433);
        chk("stall_tag_kept", 32'(EX_TASKNUM), 32'h1);

        // Debug owns the read port: nothing accepted, held entry drains.
        DBG_BUSY = 1'b1; EX_READY = 1'b1;
        #1;
        chk("dbg_id_ready", 32'(ID_READY), 32'h0);
        @(posedge CLK); @(negedge CLK);
        chk("dbg_drained", 32'(EX_VALID), 32'h0);
        DBG_BUSY = 1'b0; ID_PC = 32'h300;
        @(posedge CLK); @(negedge CLK);
        chk("post_dbg_valid", 32'(EX_VALID), 32'h1);
        chk("post_dbg_pc", EX_PC, 32'h300);

        // Reset overrides simultaneous ID and EX transfers.
        RST = 1'b1; ID_PC = 32'h400;
        #1;
        chk("rst_xfer_id_ready", 32'(ID_READY), 32'h0);
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0; ID_VALID = 1'b0;
        chk("rst_xfer_valid", 32'(EX_VALID), 32'h0);
        chk("rst_xfer_pc", EX_PC, 32'h0);
        chk("rst_xfer_inst", EX_INST, 32'h0);
        chk("rst_xfer_tag", 32'(EX_TASKNUM), 32'h0);
        chk("rst_xfer_rs1", EX_RS1, 32'h0);
        chk("rst_xfer_rs2", EX_RS2, 32'h0);

        // Randomized run against the architectural model.
        m_valid = 1'b0; m_zero = 1'b1;
        m_tag = 2'd0; m_a1 = 5'd0; m_a2 = 5'd0; m_pc = 32'h0; m_inst = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_ex_valid", 32'(EX_VALID), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_ex_tag", 32'(EX_TASKNUM), 32'(m_tag));
                chk("rnd_ex_pc", EX_PC, m_pc);
                chk("rnd_ex_inst", EX_INST, m_inst);
                chk("rnd_ex_rs1", EX_RS1, rf[m_tag][m_a1]);
                chk("rnd_ex_rs2", EX_RS2, rf[m_tag][m_a2]);
            end else if (m_zero) begin
                chk("rnd_rst_pc", EX_PC, 32'h0);
                chk("rnd_rst_rs1", EX_RS1, 32'h0);
                chk("rnd_rst_rs2", EX_RS2, 32'h0);
            end
            RST        = ($urandom_range(0, 63) == 0);
            DBG_BUSY   = ($urandom_range(0, 9) == 0);
            EX_READY   = ($urandom_range(0, 9) < 7);
            ID_VALID   = ($urandom_range(0, 3) != 0);
            ID_TASKNUM = 2'($urandom_range(0, 3));
            ID_RS1ADDR = 5'($urandom_range(0, 3));
            ID_RS2ADDR = 5'($urandom_range(0, 3));
            ID_PC      = $urandom;
            ID_INST    = $urandom;
            WB_WE      = ($urandom_range(0, 9) < 6);
            WB_TASKNUM = ($urandom_range(0, 1) == 0) ? ID_TASKNUM : 2'($urandom_range(0, 3));
            WB_WADDR   = 5'($urandom_range(0, 3));
            WB_WDATA   = $urandom;
            #1;
            exp_ready = !RST && !DBG_BUSY && (!m_valid || EX_READY);
            chk("rnd_id_ready", 32'(ID_READY), 32'(exp_ready));
            chk("rnd_rf_addr", 32'({RF_TASKNUM, RF_RS1ADDR, RF_RS2ADDR}),
                32'({ID_TASKNUM, ID_RS1ADDR, ID_RS2ADDR}));
            id_x = ID_VALID && exp_ready;
            ex_x = m_valid && EX_READY;
            @(posedge CLK);
            if (RST) begin
                m_valid = 1'b0; m_zero = 1'b1;
            end else if (id_x) begin
                m_valid = 1'b1; m_zero = 1'b0;
                m_tag = ID_TASKNUM; m_a1 = ID_RS1ADDR; m_a2 = ID_RS2ADDR;
                m_pc = ID_PC; m_inst = ID_INST;
            end else if (ex_x) begin
                m_valid = 1'b0;
            end
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
